// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the ALU reservation station.
// The renamed instruction carries its source tags, readiness bits and
// captured operand values, so an op can leave the RS fully resolved.
package uarch_pkg;

  localparam int TAG_W        = 6;
  localparam int XLEN         = 32;
  localparam int OP_W         = 4;
  localparam int ALU_RS_DEPTH = 8;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] pdst;
    logic [TAG_W-1:0] src1_tag;
    logic             src1_rdy;
    logic [XLEN-1:0]  src1_val;
    logic [TAG_W-1:0] src2_tag;
    logic             src2_rdy;
    logic [XLEN-1:0]  src2_val;
  } renamed_inst_t;

  typedef struct packed {
    logic          valid;
    renamed_inst_t inst;
  } rs_slot_t;

  // Free-slot count to the 2-bit dispatch encoding (11 is never produced).
  function automatic logic [1:0] free_to_rdy(input int free);
    if (free >= 2) begin
      return 2'b10;
    end else if (free == 1) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

endpackage

// File: rtl/alu_rs_prio_enc.sv
// LSB-first priority encoder: picks the lowest-index set request and
// reports it both as a one-hot vector and as a binary index.
module prio_enc_lsb #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  // below[i] is set when any request exists strictly beneath bit i
  logic [N:0] below;

  assign below[0] = 1'b0;

  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    assign below[gi+1] = below[gi] | req[gi];
    assign onehot[gi]  = req[gi] & ~below[gi];
  end

  assign found = below[N];

  // Binary index of the winning bit (onehot guarantees a single contributor)
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: collapsing queue of renamed ops with slot 0 as
// the oldest. Snoops the CDB for operand wakeup, issues the oldest fully
// ready op each cycle and reports free capacity back to dispatch.
module alu_rs
  import uarch_pkg::*;
#(
  parameter int DEPTH      = ALU_RS_DEPTH,
  parameter int CDB_PORTS  = 2,
  parameter bit DROP_CHECK = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [1:0]                      alu_rs_we,
  input  renamed_inst_t                   alu_rs_entry0,
  input  renamed_inst_t                   alu_rs_entry1,
  output logic [1:0]                      alu_rs_rdy,
  input  logic [CDB_PORTS-1:0]            cdb_valid,
  input  logic [CDB_PORTS-1:0][TAG_W-1:0] cdb_tag,
  input  logic [CDB_PORTS-1:0][XLEN-1:0]  cdb_data,
  output logic                            issue_valid,
  output renamed_inst_t                   issue_inst,
  input  logic                            issue_rdy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  rs_slot_t         slot_reg   [DEPTH];
  rs_slot_t         slot_next  [DEPTH];
  rs_slot_t         woken_slot [DEPTH];
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] sel_onehot;
  logic [IW-1:0]    sel_idx;
  logic             sel_found;
  logic             fire;

  // Capture any pending source whose tag is on the CDB this cycle.
  // Ports are scanned high to low so port 0 wins on duplicate tags.
  function automatic renamed_inst_t wakeup(
    input renamed_inst_t                   inst,
    input logic [CDB_PORTS-1:0]            v,
    input logic [CDB_PORTS-1:0][TAG_W-1:0] tag,
    input logic [CDB_PORTS-1:0][XLEN-1:0]  data
  );
    renamed_inst_t res;
    res = inst;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (v[p] && !inst.src1_rdy && (tag[p] == inst.src1_tag)) begin
        res.src1_rdy = 1'b1;
        res.src1_val = data[p];
      end
      if (v[p] && !inst.src2_rdy && (tag[p] == inst.src2_tag)) begin
        res.src2_rdy = 1'b1;
        res.src2_val = data[p];
      end
    end
    return res;
  endfunction

  // Readiness uses registered bits only; wakeup results feed next state.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign ready[gi] = slot_reg[gi].valid && slot_reg[gi].inst.src1_rdy &&
                       slot_reg[gi].inst.src2_rdy;
    assign woken_slot[gi].valid = slot_reg[gi].valid;
    assign woken_slot[gi].inst  = wakeup(slot_reg[gi].inst, cdb_valid, cdb_tag, cdb_data);
  end

  prio_enc_lsb #(.N(DEPTH)) u_select (
    .req    (ready),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .found  (sel_found)
  );

  assign issue_valid = sel_found;
  assign fire        = sel_found && issue_rdy;
  assign alu_rs_rdy  = free_to_rdy(DEPTH - int'(count_reg));

  // Oldest ready op to the ALU; all-zero when nothing is ready
  always_comb begin
    issue_inst = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_onehot[i]) begin
        issue_inst = slot_reg[i].inst;
      end
    end
  end

  // Next state: wakeup, collapse over the issued slot, then tail append
  always_comb begin
    int   free_cnt;
    int   base;
    logic acc0;
    logic acc1;

    free_cnt = DEPTH - int'(count_reg);
    // Admission is judged against the advertised free count, so a
    // same-cycle issue never lets an extra write in.
    acc0 = alu_rs_we[0] && (free_cnt >= 1);
    acc1 = alu_rs_we[1] && (free_cnt >= (acc0 ? 2 : 1));
    base = int'(count_reg) - (fire ? 1 : 0);

    for (int i = 0; i < DEPTH; i++) begin
      if (fire && (i >= int'(sel_idx))) begin
        if (i < DEPTH - 1) begin
          slot_next[i] = woken_slot[i+1];
        end else begin
          slot_next[i] = '0;
        end
      end else begin
        slot_next[i] = woken_slot[i];
      end

      if (acc0 && (i == base)) begin
        slot_next[i].valid = 1'b1;
        slot_next[i].inst  = wakeup(alu_rs_entry0, cdb_valid, cdb_tag, cdb_data);
      end
      if (acc1 && (i == base + (acc0 ? 1 : 0))) begin
        slot_next[i].valid = 1'b1;
        slot_next[i].inst  = wakeup(alu_rs_entry1, cdb_valid, cdb_tag, cdb_data);
      end
    end

    count_next = CW'(base + (acc0 ? 1 : 0) + (acc1 ? 1 : 0));

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_next[i] = '0;
      end
      count_next = '0;
    end
  end

  // Slot and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_reg[i] <= '0;
      end
      count_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_reg[i] <= slot_next[i];
      end
      count_reg <= count_next;
    end
  end

  // Dispatch must never offer more ops than the advertised free slots
  if (DROP_CHECK) begin : g_drop_chk
    logic [CW-1:0] wr_req;
    logic [CW-1:0] free_slots;

    assign wr_req     = CW'(alu_rs_we[0]) + CW'(alu_rs_we[1]);
    assign free_slots = CW'(DEPTH) - count_reg;

    a_no_drop: assert property (@(posedge clk) disable iff (!rst_n)
      !flush |-> (wr_req <= free_slots))
      else $error("alu_rs: write offered with no free slot, entry dropped");
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: reset, issue order, CDB wakeup and bypass,
// fill/drop behaviour, collapse, oldest-first select, flush and async reset.
module tb_alu_rs;
  import uarch_pkg::*;

  localparam int NP = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic [1:0]               we;
  renamed_inst_t            e0;
  renamed_inst_t            e1;
  logic [1:0]               rdy;
  logic [NP-1:0]            cdb_valid;
  logic [NP-1:0][TAG_W-1:0] cdb_tag;
  logic [NP-1:0][XLEN-1:0]  cdb_data;
  logic                     issue_valid;
  renamed_inst_t            issue_inst;
  logic                     issue_rdy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_rs #(.DEPTH(8), .CDB_PORTS(NP), .DROP_CHECK(1'b0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .alu_rs_we     (we),
    .alu_rs_entry0 (e0),
    .alu_rs_entry1 (e1),
    .alu_rs_rdy    (rdy),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .issue_valid   (issue_valid),
    .issue_inst    (issue_inst),
    .issue_rdy     (issue_rdy)
  );

  function automatic renamed_inst_t mk(input logic [5:0] pdst,
                                       input logic [5:0] t1, input logic r1, input logic [31:0] v1,
                                       input logic [5:0] t2, input logic r2, input logic [31:0] v2);
    renamed_inst_t r;
    r.op = pdst[3:0]; r.pdst = pdst;
    r.src1_tag = t1; r.src1_rdy = r1; r.src1_val = v1;
    r.src2_tag = t2; r.src2_rdy = r2; r.src2_val = v2;
    return r;
  endfunction

  // src1 waits on tag t; src2 already holds 0x55
  function automatic renamed_inst_t pend(input logic [5:0] t);
    return mk(t, t, 1'b0, 32'h0, 6'd0, 1'b1, 32'h55);
  endfunction

  function automatic renamed_inst_t woke(input logic [5:0] t, input logic [31:0] d);
    return mk(t, t, 1'b1, d, 6'd0, 1'b1, 32'h55);
  endfunction

  function automatic renamed_inst_t rdy_op(input logic [5:0] t);
    return mk(t, 6'd0, 1'b1, 32'h100 + 32'(t), 6'd0, 1'b1, 32'h200 + 32'(t));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb_clear();
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic cdb_set(input int p, input logic [5:0] t, input logic [31:0] d);
    cdb_valid[p] = 1'b1; cdb_tag[p] = t; cdb_data[p] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; we = 2'b00; e0 = '0; e1 = '0; issue_rdy = 1'b0;
    cdb_clear();
    tick(); tick();
    checks++; if (rdy !== 2'b10) begin failures++; $display("FAIL reset_rdy got=%b exp=10", rdy); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", issue_valid); end
    checks++; if (issue_inst !== renamed_inst_t'(0)) begin failures++; $display("FAIL reset_inst got=%h exp=0", issue_inst); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (rdy !== 2'b10) begin failures++; $display("FAIL idle_rdy got=%b exp=10", rdy); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", issue_valid); end
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    e0 = rdy_op(6'd1); e1 = rdy_op(6'd2); we = 2'b11; issue_rdy = 1'b1;
    tick();
    we = 2'b00;
    checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid0 got=%b exp=1", issue_valid); end
    checks++; if (issue_inst !== rdy_op(6'd1)) begin failures++; $display("FAIL b2b_inst0 got=%h exp=%h", issue_inst, rdy_op(6'd1)); end
    checks++; if (rdy !== 2'b10) begin failures++; $display("FAIL b2b_rdy got=%b exp=10", rdy); end
    tick();
    checks++; if (issue_inst !== rdy_op(6'd2)) begin failures++; $display("FAIL b2b_inst1 got=%h exp=%h", issue_inst, rdy_op(6'd2)); end
    tick();
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", issue_valid); end
    issue_rdy = 1'b0;
    $display("test_back_to_back done");
  endtask

  task automatic test_wakeup();
    e0 = pend(6'd5); we = 2'b01;
    tick();
    we = 2'b00;
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wk_pending got=%b exp=0", issue_valid); end
    cdb_set(0, 6'd5, 32'hDEAD);
    tick();
    cdb_clear();
    checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL wk_valid got=%b exp=1", issue_valid); end
    checks++; if (issue_inst !== woke(6'd5, 32'hDEAD)) begin failures++; $display("FAIL wk_inst got=%h exp=%h", issue_inst, woke(6'd5, 32'hDEAD)); end
    issue_rdy = 1'b1;
    tick();
    issue_rdy = 1'b0;
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wk_drain got=%b exp=0", issue_valid); end
    // bypass: entry1 alone, woken by port 1 in its write cycle
    e1 = pend(6'd5); we = 2'b10;
    cdb_set(1, 6'd5, 32'hBEEF);
    tick();
    we = 2'b00; cdb_clear();
    checks++; if (issue_inst !== woke(6'd5, 32'hBEEF) || issue_valid !== 1'b1) begin failures++; $display("FAIL bypass_inst got=%h exp=%h", issue_inst, woke(6'd5, 32'hBEEF)); end
    issue_rdy = 1'b1;
    tick();
    issue_rdy = 1'b0;
    // duplicate tag on both ports: port 0 data wins
    e0 = mk(6'd6, 6'd0, 1'b1, 32'h77, 6'd7, 1'b0, 32'h0); we = 2'b01;
    tick();
    we = 2'b00;
    cdb_set(0, 6'd7, 32'h1111); cdb_set(1, 6'd7, 32'h2222);
    tick();
    cdb_clear();
    checks++; if (issue_inst !== mk(6'd6, 6'd0, 1'b1, 32'h77, 6'd7, 1'b1, 32'h1111)) begin failures++; $display("FAIL dup_tag got=%h exp src2_val=1111", issue_inst); end
    issue_rdy = 1'b1;
    tick();
    issue_rdy = 1'b0;
    checks++; if (issue_valid !== 1'b0 || rdy !== 2'b10) begin failures++; $display("FAIL wk_end got=%b/%b exp=0/10", issue_valid, rdy); end
    $display("test_wakeup done");
  endtask

  task automatic test_full();
    for (int k = 0; k < 3; k++) begin
      e0 = pend(6'(10 + 2*k)); e1 = pend(6'(11 + 2*k)); we = 2'b11;
      tick();
      checks++; if (rdy !== 2'b10) begin failures++; $display("FAIL fill_rdy k=%0d got=%b exp=10", k, rdy); end
    end
    e0 = pend(6'd16); we = 2'b01;
    tick();
    checks++; if (rdy !== 2'b01) begin failures++; $display("FAIL fill7_rdy got=%b exp=01", rdy); end
    e0 = pend(6'd17); e1 = pend(6'd18); we = 2'b11;
    tick();
    checks++; if (rdy !== 2'b00) begin failures++; $display("FAIL fill8_rdy got=%b exp=00", rdy); end
    e0 = pend(6'd19); e1 = pend(6'd20); we = 2'b11;
    tick();
    we = 2'b00;
    checks++; if (rdy !== 2'b00 || issue_valid !== 1'b0) begin failures++; $display("FAIL drop_full got=%b/%b exp=00/0", rdy, issue_valid); end
    cdb_set(0, 6'd13, 32'h1013);
    tick();
    cdb_clear();
    checks++; if (issue_valid !== 1'b1 || issue_inst !== woke(6'd13, 32'h1013)) begin failures++; $display("FAIL slot3_inst got=%h exp=%h", issue_inst, woke(6'd13, 32'h1013)); end
    issue_rdy = 1'b1;
    tick();
    issue_rdy = 1'b0;
    checks++; if (issue_valid !== 1'b0 || rdy !== 2'b01) begin failures++; $display("FAIL slot3_after got=%b/%b exp=0/01", issue_valid, rdy); end
    cdb_set(1, 6'd17, 32'h1017);
    tick();
    cdb_clear();
    checks++; if (issue_inst !== woke(6'd17, 32'h1017)) begin failures++; $display("FAIL partial_write got=%h exp=%h", issue_inst, woke(6'd17, 32'h1017)); end
    issue_rdy = 1'b1;
    tick();
    issue_rdy = 1'b0;
    checks++; if (issue_valid !== 1'b0 || rdy !== 2'b10) begin failures++; $display("FAIL slot6_after got=%b/%b exp=0/10", issue_valid, rdy); end
    cdb_set(0, 6'd18, 32'h1018); cdb_set(1, 6'd19, 32'h1019);
    tick();
    cdb_clear();
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL dropped_woke got=%b exp=0", issue_valid); end
    $display("test_full done");
  endtask

  task automatic test_oldest_first();
    // queue now holds tags 10,11,12,14,15,16
    cdb_set(0, 6'd11, 32'h2011); cdb_set(1, 6'd15, 32'h2015);
    tick();
    cdb_clear();
    checks++; if (issue_inst !== woke(6'd11, 32'h2011)) begin failures++; $display("FAIL oldest_1 got=%h exp=%h", issue_inst, woke(6'd11, 32'h2011)); end
    issue_rdy = 1'b1;
    cdb_set(0, 6'd12, 32'h2012);
    tick();
    cdb_clear();
    checks++; if (issue_inst !== woke(6'd12, 32'h2012)) begin failures++; $display("FAIL shift_wake got=%h exp=%h", issue_inst, woke(6'd12, 32'h2012)); end
    tick();
    checks++; if (issue_inst !== woke(6'd15, 32'h2015)) begin failures++; $display("FAIL oldest_4 got=%h exp=%h", issue_inst, woke(6'd15, 32'h2015)); end
    tick();
    issue_rdy = 1'b0;
    checks++; if (issue_valid !== 1'b0 || rdy !== 2'b10) begin failures++; $display("FAIL oldest_end got=%b/%b exp=0/10", issue_valid, rdy); end
    $display("test_oldest_first done");
  endtask

  task automatic test_flush();
    // 3 left (10,14,16); add 3 more for 6 valid, one of them ready
    e0 = pend(6'd21); e1 = pend(6'd22); we = 2'b11;
    tick();
    e0 = rdy_op(6'd23); we = 2'b01;
    tick();
    we = 2'b00;
    checks++; if (issue_valid !== 1'b1 || issue_inst !== rdy_op(6'd23)) begin failures++; $display("FAIL preflush_inst got=%h exp=%h", issue_inst, rdy_op(6'd23)); end
    flush = 1'b1; e0 = rdy_op(6'd24); e1 = rdy_op(6'd25); we = 2'b11; issue_rdy = 1'b1;
    tick();
    flush = 1'b0; we = 2'b00;
    checks++; if (rdy !== 2'b10) begin failures++; $display("FAIL flush_rdy got=%b exp=10", rdy); end
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", issue_valid); end
    checks++; if (issue_inst !== renamed_inst_t'(0)) begin failures++; $display("FAIL flush_inst got=%h exp=0", issue_inst); end
    cdb_set(0, 6'd10, 32'h3010); cdb_set(1, 6'd21, 32'h3021);
    tick();
    cdb_clear();
    issue_rdy = 1'b0;
    checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL flush_stale got=%b exp=0", issue_valid); end
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    e0 = rdy_op(6'd30); e1 = rdy_op(6'd31); we = 2'b11;
    tick();
    we = 2'b00;
    checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_valid got=%b exp=1", issue_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (issue_valid !== 1'b0 || rdy !== 2'b10) begin failures++; $display("FAIL async_rst got=%b/%b exp=0/10", issue_valid, rdy); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (issue_valid !== 1'b0 || issue_inst !== renamed_inst_t'(0)) begin failures++; $display("FAIL post_rst got=%b/%h exp=0/0", issue_valid, issue_inst); end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wakeup();
    test_full();
    test_oldest_first();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
